// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared FSM state encoding, HALT word and default sizes
//   for the instruction fetch unit and its instruction memory.
package instr_fetch_pkg;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 16;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALT} state_t;
endpackage

// File: rtl/instr_fetch_mem.sv
// instr_mem: DEPTH x DW instruction store, synchronous write and read.
//   clock        rising-edge clock
//   we/waddr/wdata  write port
//   re/raddr     read enable and address; rdata valid the cycle after re
//   rdata        registered read data (holds when re is low)
// Contents are never reset.
module instr_mem
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequences instructions from instr_mem to a processor.
//   clock, resetn     clock and asynchronous active-low reset
//   load_en/addr/data program load port, honoured only in IDLE or HALT
//   start             begin execution at address 0 (IDLE or HALT only)
//   done              processor finished the instruction in iin (WAIT only)
//   iin, iin_valid    current instruction and its valid flag
//   pc                address of the instruction in iin
//   halted            a HALT word was fetched
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  input  logic          done,
  output logic [DW-1:0] iin,
  output logic          iin_valid,
  output logic [AW-1:0] pc,
  output logic          halted
);
  state_t state, next;
  logic [DW-1:0] rdata;
  logic stopped;
  assign stopped = state == S_IDLE || state == S_HALT;
  assign iin_valid = state == S_WAIT;
  assign halted = state == S_HALT;
  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_HALT: next = start ? S_FETCH : state;
      S_FETCH: next = S_ISSUE;
      S_ISSUE: next = rdata == DW'(HALT_WORD) ? S_HALT : S_WAIT;
      S_WAIT: next = done ? S_FETCH : S_WAIT;
      default: next = S_IDLE;
    endcase
  end
  // pc wraps naturally in AW bits since 2^AW == DEPTH
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      pc <= '0;
      iin <= '0;
    end else begin
      state <= next;
      if (stopped && start) pc <= '0;
      else if (state == S_WAIT && done) pc <= pc + AW'(1);
      if (state == S_ISSUE) iin <= rdata;
    end
  end
  instr_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_mem (
    .clock(clock),
    .we(load_en && stopped),
    .waddr(load_addr),
    .wdata(load_data),
    .re(state == S_FETCH),
    .raddr(pc),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch (tables, corner sequences, random programs vs. a trace model).
module tb_instr_fetch;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int DW = 16;
  logic clock = 0, resetn = 0, load_en = 0, start = 0, done = 0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic [DW-1:0] iin;
  logic iin_valid, halted;
  logic [AW-1:0] pc;
  int compared = 0, mismatched = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  typedef struct {logic [DW-1:0] iin; logic [AW-1:0] pc;} exp_t;
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} ld_t;
  exp_t tbl [4];
  ld_t prog [5];
  int lat, hp;

  instr_fetch dut (
    .clock(clock), .resetn(resetn), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .done(done), .iin(iin),
    .iin_valid(iin_valid), .pc(pc), .halted(halted)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en = 1; load_addr = a; load_data = d;
    step();
    load_en = 0;
    ref_mem[a] = d;
  endtask

  // step until an instruction or halt appears; lat = edges since the start/done edge
  task automatic advance(output int l);
    l = 0;
    do begin
      step();
      start = 0; done = 0;
      l++;
    end while (!iin_valid && !halted && l < 12);
  endtask

  task automatic do_reset();
    resetn = 0;
    step();
    resetn = 1;
  endtask

  // Model: execution is the memory walked sequentially from 0 until a HALT word.
  task automatic run_prog(input int n_max, input int dmax);
    exp_t tr[$];
    exp_t e;
    int p, h, l, d;
    p = 0; h = -1;
    for (int i = 0; i < n_max; i++) begin
      if (ref_mem[p] == 16'hFFFF) begin h = p; break; end
      e.iin = ref_mem[p]; e.pc = AW'(p);
      tr.push_back(e);
      p = (p + 1) % DEPTH;
    end
    for (int i = 0; i < tr.size(); i++) begin
      if (i == 0) start = 1; else done = 1;
      advance(l);
      chk("rp_latency", l, 3);
      chk("rp_iin", iin, tr[i].iin);
      chk("rp_pc", pc, tr[i].pc);
      d = $urandom_range(0, dmax);
      repeat (d) step();
      chk("rp_hold_valid", iin_valid, 1);
      chk("rp_hold_iin", iin, tr[i].iin);
    end
    if (h >= 0) begin
      if (tr.size() == 0) start = 1; else done = 1;
      advance(l);
      chk("rp_halt_lat", l, 3);
      chk("rp_halted", halted, 1);
      chk("rp_halt_pc", pc, h);
      chk("rp_halt_valid", iin_valid, 0);
    end
  endtask

  initial begin
    prog = '{'{5'd0, 16'hA01C}, '{5'd1, 16'hA40A}, '{5'd2, 16'h2080}, '{5'd3, 16'h8000}, '{5'd4, 16'hFFFF}};
    tbl = '{'{16'hA01C, 5'd0}, '{16'hA40A, 5'd1}, '{16'h2080, 5'd2}, '{16'h8000, 5'd3}};
    step();
    chk("rst_iin", iin, 0);
    chk("rst_valid", iin_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    resetn = 1;
    for (int i = 0; i < DEPTH; i++) load(AW'(i), DW'(16'h1000 + i));
    foreach (prog[i]) load(prog[i].addr, prog[i].data);
    // table: basic program, done 4 cycles after each valid
    start = 1;
    advance(lat);
    chk("start_latency", lat, 3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        done = 1;
        advance(lat);
        chk("done_latency", lat, 3);
      end
      chk("tbl_iin", iin, tbl[i].iin);
      chk("tbl_pc", pc, tbl[i].pc);
      chk("tbl_valid", iin_valid, 1);
      repeat (4) step();
      chk("tbl_hold_iin", iin, tbl[i].iin);
    end
    done = 1;
    advance(lat);
    chk("halt_halted", halted, 1);
    chk("halt_pc", pc, 4);
    chk("halt_valid", iin_valid, 0);
    // done held high: one instruction every 3 cycles
    done = 1; start = 1;
    step();
    start = 0;
    for (int k = 1; k <= 15; k++) begin
      chk("held_valid", iin_valid, (k % 3 == 0 && k <= 12));
      chk("held_halted", halted, (k == 15));
      if (k % 3 == 0 && k <= 12) chk("held_iin", iin, tbl[k / 3 - 1].iin);
      if (k < 15) step();
    end
    done = 0;
    // load and start ignored during WAIT
    start = 1;
    advance(lat);
    chk("w_iin0", iin, 16'hA01C);
    load_en = 1; load_addr = 5'd1; load_data = 16'h0000; start = 1;
    step();
    load_en = 0; start = 0;
    chk("w_pc", pc, 0);
    chk("w_valid", iin_valid, 1);
    chk("w_iin", iin, 16'hA01C);
    done = 1;
    advance(lat);
    chk("w_iin1", iin, 16'hA40A);
    chk("w_pc1", pc, 1);
    // asynchronous reset mid-instruction at pc=2
    done = 1;
    advance(lat);
    chk("r_pc2", pc, 2);
    resetn = 0;
    #1;
    chk("r_iin", iin, 0);
    chk("r_valid", iin_valid, 0);
    chk("r_pc", pc, 0);
    chk("r_halted", halted, 0);
    @(negedge clock);
    resetn = 1;
    run_prog(DEPTH + 1, 2);
    // load and start in the same HALT cycle
    load_en = 1; load_addr = 5'd0; load_data = 16'h5A5A; start = 1;
    ref_mem[0] = 16'h5A5A;
    advance(lat);
    load_en = 0;
    chk("ls_latency", lat, 3);
    chk("ls_iin", iin, 16'h5A5A);
    do_reset();
    // no HALT word: pc wraps after address 31
    for (int i = 0; i < DEPTH; i++) load(AW'(i), DW'($urandom_range(0, 16'hFFFE)));
    run_prog(DEPTH + 1, 1);
    do_reset();
    // random programs with HALT at a random address
    for (int r = 0; r < 6; r++) begin
      hp = $urandom_range(0, DEPTH - 1);
      for (int i = 0; i < DEPTH; i++)
        load(AW'(i), i == hp ? 16'hFFFF : (i < hp ? DW'($urandom_range(0, 16'hFFFE)) : DW'($urandom)));
      run_prog(DEPTH + 1, 5);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 32: number of instruction-memory words.
REQ-002 Parameter AW, default 5: address width; the block SHALL treat 2^AW == DEPTH as a fixed requirement.
REQ-003 Parameter DW, default 16: instruction width.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 load_en  in  1  write strobe for program loading.
REQ-007 load_addr  in  AW  write address.
REQ-008 load_data  in  DW  write data.
REQ-009 start  in  1  one-cycle pulse; begins execution at address 0.
REQ-010 done  in  1  processor has completed the current instruction.
REQ-011 iin  out  DW  registered instruction word that drives the processor iin port.
REQ-012 iin_valid  out  1  iin holds an instruction awaiting completion.
REQ-013 pc  out  AW  address of the instruction in iin.
REQ-014 halted  out  1  a HALT word was fetched; execution has stopped.

Function
REQ-015 The block SHALL implement a FSM with states IDLE, FETCH, ISSUE, WAIT and HALT.
REQ-016 IDLE: on start, pc <= 0 and next state FETCH; otherwise the FSM stays in IDLE.
REQ-017 FETCH: the block SHALL issue a synchronous read of mem[pc]; next state ISSUE.
REQ-018 ISSUE: the block SHALL latch the read data into iin; if the data equals HALT_WORD (16'hFFFF), next state is HALT with iin_valid=0; otherwise iin_valid <= 1 and next state is WAIT.
REQ-019 WAIT: iin and iin_valid SHALL stay stable until done=1; on done, iin_valid <= 0, pc <= pc+1 (mod DEPTH, so DEPTH-1 wraps to 0) and next state FETCH.
REQ-020 Latency: start in cycle t SHALL give iin_valid=1 in cycle t+3; done in cycle u SHALL give the next iin_valid=1 in cycle u+3.
REQ-021 HALT: halted=1 and pc holds the HALT address; start SHALL clear halted, set pc <= 0 and move to FETCH.
REQ-022 load_en SHALL write mem[load_addr] only in IDLE or HALT; in other states it SHALL be ignored.
REQ-023 start SHALL be ignored in FETCH, ISSUE and WAIT.
REQ-024 done SHALL be ignored outside WAIT.
REQ-025 If load_en and start are asserted in the same cycle in IDLE/HALT, the write SHALL complete and the FSM SHALL move to FETCH; a read of that address in the next FETCH SHALL return the new data.
REQ-026 iin SHALL retain its last value outside ISSUE/WAIT.

Reset
REQ-027 On resetn=0, at any time including mid-instruction: state=IDLE, pc=0, iin=0, iin_valid=0, halted=0, asynchronously.
REQ-028 Instruction memory contents SHALL NOT be cleared by reset.
REQ-029 The first active edge after resetn rises SHALL be able to accept start or load_en.

Structure
REQ-030 A shared include/package SHALL hold the FSM state encodings, HALT_WORD and the default DEPTH/AW/DW values.
REQ-031 The block SHALL contain one sub-module, instr_mem: a DEPTH x DW memory with synchronous write and synchronous read.
REQ-032 The pc counter and the FSM SHALL reside in instr_fetch.

Verification
REQ-033 Load A01C, A40A, 2080, 8000, FFFF at addresses 0..4, then start -> iin=A01C, pc=0 and iin_valid=1 three cycles after start.
REQ-034 Same program with done pulsed 4 cycles after each iin_valid -> iin sequence A01C, A40A, 2080, 8000; then halted=1, pc=4, iin_valid=0.
REQ-035 Hold done high continuously -> a new instruction every 3 cycles; iin_valid low for 2 cycles between instructions.
REQ-036 Pulse load_en to address 1 with data 0000 during WAIT -> mem[1] unchanged; second instruction is still A40A.
REQ-037 Drive resetn low during WAIT at pc=2 -> all outputs 0 immediately; a following start re-executes from A01C.
REQ-038 Program with no HALT word and DEPTH=32 -> after the instruction at address 31 completes, pc wraps to 0 and iin=mem[0].
